// File: rtl/mem_lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// Op codes, FSM states, access widths, RAM strobe levels and byte-lane helpers.
package mem_lsu_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } lsu_state_e;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    function automatic logic is_load(input lsu_op_e op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] off);
        case (op)
            OP_LH, OP_LHU, OP_SH: return off[0];
            OP_LW, OP_SW:         return |off;
            default:              return 1'b0;
        endcase
    endfunction

    // Physical lane holding byte offset `off` of the addressed word.
    function automatic logic [1:0] lane_of(input logic [1:0] off, input logic big_endian);
        return big_endian ? (2'd3 - off) : off;
    endfunction

    // True when the addressed halfword lives in bits [31:16].
    function automatic logic half_is_upper(input logic [1:0] off, input logic big_endian);
        return big_endian ? ~off[1] : off[1];
    endfunction

    function automatic logic [3:0] store_sel(input lsu_op_e op, input logic [1:0] off,
                                             input logic big_endian);
        case (op)
            OP_SB:   return 4'b0001 << lane_of(off, big_endian);
            OP_SH:   return half_is_upper(off, big_endian) ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] store_data(input lsu_op_e op,
                                                     input logic [WORD_W-1:0] d);
        case (op)
            OP_SB:   return {4{d[BYTE_W-1:0]}};
            OP_SH:   return {2{d[HALF_W-1:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_extract.sv
// Picks the addressed byte/halfword out of a RAM word and sign/zero-extends it.
// Purely combinational; used on the read-return path of mem_lsu.
module lsu_lane_extract
    import mem_lsu_pkg::*;
#(
    parameter logic BIG_ENDIAN = 1'b1
) (
    input  lsu_op_e            op_i,
    input  logic [1:0]         offset_i,
    input  logic [WORD_W-1:0]  word_i,
    output logic [WORD_W-1:0]  result_o
);

    logic [BYTE_W-1:0] byte_v;
    logic [HALF_W-1:0] half_v;

    always_comb begin
        byte_v = BYTE_W'(word_i >> {lane_of(offset_i, BIG_ENDIAN), 3'b000});
        half_v = half_is_upper(offset_i, BIG_ENDIAN) ? word_i[31:16] : word_i[15:0];
        case (op_i)
            OP_LB:   result_o = {{(WORD_W-BYTE_W){byte_v[BYTE_W-1]}}, byte_v};
            OP_LBU:  result_o = {{(WORD_W-BYTE_W){1'b0}}, byte_v};
            OP_LH:   result_o = {{(WORD_W-HALF_W){half_v[HALF_W-1]}}, half_v};
            OP_LHU:  result_o = {{(WORD_W-HALF_W){1'b0}}, half_v};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one request at a time against a synchronous data RAM.
// Drives registered RAM strobes, extracts load data, reports misalignment exceptions.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter logic BIG_ENDIAN = 1'b1,
    parameter int   MEM_ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [2:0]            req_op_i,
    input  logic [31:0]           req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  done_o,
    output logic [31:0]           rdata_o,
    output logic                  adel_o,
    output logic                  ades_o,
    output logic                  ram_ce_o,
    output logic                  ram_we_o,
    output logic [MEM_ADDR_W-1:0] ram_addr_o,
    output logic [3:0]            ram_sel_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i
);

    lsu_state_e            state_q, state_d;
    lsu_op_e               op_q, op_d;
    logic [1:0]            offset_q, offset_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  adel_q, adel_d;
    logic                  ades_q, ades_d;
    logic                  ce_q, ce_d;
    logic                  we_q, we_d;
    logic [MEM_ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [3:0]            sel_q, sel_d;
    logic [31:0]           ram_wdata_q, ram_wdata_d;

    lsu_op_e     req_op;
    logic [31:0] load_result;

    assign req_op = lsu_op_e'(req_op_i);

    lsu_lane_extract #(.BIG_ENDIAN(BIG_ENDIAN)) u_extract (
        .op_i     (op_q),
        .offset_i (offset_q),
        .word_i   (ram_rdata_i),
        .result_o (load_result)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        offset_d    = offset_q;
        ready_d     = 1'b0;
        done_d      = 1'b0;
        rdata_d     = rdata_q;
        adel_d      = 1'b0;
        ades_d      = 1'b0;
        ce_d        = CHIP_DISABLE;
        we_d        = WRITE_DISABLE;
        sel_d       = 4'b0000;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (req_valid_i && ready_q) begin
                    ready_d  = 1'b0;
                    op_d     = req_op;
                    offset_d = req_addr_i[1:0];
                    if (is_misaligned(req_op, req_addr_i[1:0])) begin
                        // Exception goes straight to the response; the RAM never sees it.
                        state_d = ST_RESP;
                        done_d  = 1'b1;
                        rdata_d = '0;
                        adel_d  = is_load(req_op);
                        ades_d  = ~is_load(req_op);
                    end else begin
                        state_d     = ST_ACCESS;
                        ce_d        = CHIP_ENABLE;
                        we_d        = is_load(req_op) ? WRITE_DISABLE : WRITE_ENABLE;
                        sel_d       = is_load(req_op) ? 4'b1111
                                    : store_sel(req_op, req_addr_i[1:0], BIG_ENDIAN);
                        ram_addr_d  = {req_addr_i[MEM_ADDR_W-1:2], 2'b00};
                        ram_wdata_d = store_data(req_op, req_wdata_i);
                    end
                end
            end
            ST_ACCESS: begin
                if (is_load(op_q)) begin
                    state_d = ST_RD_WAIT;
                end else begin
                    state_d = ST_RESP;
                    done_d  = 1'b1;
                    rdata_d = '0;
                end
            end
            ST_RD_WAIT: begin
                state_d = ST_RESP;
                done_d  = 1'b1;
                rdata_d = load_result;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LB;
            offset_q    <= 2'b00;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            rdata_q     <= '0;
            adel_q      <= 1'b0;
            ades_q      <= 1'b0;
            ce_q        <= CHIP_DISABLE;
            we_q        <= WRITE_DISABLE;
            ram_addr_q  <= '0;
            sel_q       <= 4'b0000;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            offset_q    <= offset_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            adel_q      <= adel_d;
            ades_q      <= ades_d;
            ce_q        <= ce_d;
            we_q        <= we_d;
            ram_addr_q  <= ram_addr_d;
            sel_q       <= sel_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign req_ready_o = ready_q;
    assign done_o      = done_q;
    assign rdata_o     = rdata_q;
    assign adel_o      = adel_q;
    assign ades_o      = ades_q;
    assign ram_ce_o    = ce_q;
    assign ram_we_o    = we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_sel_o   = sel_q;
    assign ram_wdata_o = ram_wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: byte-addressed reference memory plus a per-cycle expectation
// timeline built from request latencies; a sync RAM model sits on the RAM port.
module tb_mem_lsu;

    localparam int MAXC = 6000;
    localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3, LW = 3'd4,
                           SB = 3'd5, SH = 3'd6, SW = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  req_op_i = '0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        adel_o, ades_o;
    logic        ram_ce_o, ram_we_o;
    logic [31:0] ram_addr_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i = '0;

    mem_lsu #(.BIG_ENDIAN(1'b1), .MEM_ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .done_o(done_o), .rdata_o(rdata_o), .adel_o(adel_o), .ades_o(ades_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_sel_o(ram_sel_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk = ~clk;

    // Sync RAM on the DUT's RAM port (big-endian lanes: byte offset k in lane 3-k).
    logic [31:0] ram [64];
    always @(posedge clk) begin
        if (ram_ce_o) begin
            if (ram_we_o) begin
                for (int i = 0; i < 4; i++)
                    if (ram_sel_o[i]) ram[ram_addr_o[7:2]][8*i +: 8] <= ram_wdata_o[8*i +: 8];
            end else begin
                ram_rdata_i <= ram[ram_addr_o[7:2]];
            end
        end
    end

    // Reference: architectural byte memory and per-cycle expected outputs.
    logic [7:0]  ref_b [256];
    bit          exp_busy [MAXC], exp_done [MAXC], exp_adel [MAXC], exp_ades [MAXC];
    bit          exp_ce [MAXC], exp_we [MAXC], exp_rst [MAXC];
    logic [3:0]  exp_sel [MAXC];
    logic [31:0] exp_wdata [MAXC], exp_addr [MAXC], exp_rdv [MAXC];

    int cyc = 0;
    int n_chk = 0, n_pass = 0;
    int ce_cnt = 0, done_at = -1, strobe_at = -1;
    logic [31:0] done_rd, strobe_wdata, strobe_addr;
    logic [3:0]  strobe_sel;
    logic        done_adel, done_ades;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    endtask

    function automatic bit mdl_mis(input logic [2:0] op, input logic [31:0] a);
        if (op == LH || op == LHU || op == SH) return a[0];
        if (op == LW || op == SW) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [2:0] op, input logic [7:0] a);
        logic [15:0] h;
        h = {ref_b[a], ref_b[8'(a + 1)]};
        case (op)
            LB:      return {{24{ref_b[a][7]}}, ref_b[a]};
            LBU:     return {24'h0, ref_b[a]};
            LH:      return {{16{h[15]}}, h};
            LHU:     return {16'h0, h};
            default: return {ref_b[a], ref_b[8'(a + 1)], ref_b[8'(a + 2)], ref_b[8'(a + 3)]};
        endcase
    endfunction

    task automatic schedule(input int c, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] d);
        int t;
        bit ld;
        ld = op <= LW;
        if (mdl_mis(op, a)) begin
            t = c + 1;
            exp_adel[t] = ld;
            exp_ades[t] = !ld;
            exp_rdv[t]  = 32'h0;
        end else begin
            exp_ce[c+1]   = 1'b1;
            exp_we[c+1]   = !ld;
            exp_addr[c+1] = {a[31:2], 2'b00};
            if (ld) begin
                exp_sel[c+1] = 4'b1111;
                t = c + 3;
                exp_rdv[t] = mdl_load(op, a[7:0]);
            end else begin
                t = c + 2;
                exp_rdv[t] = 32'h0;
                case (op)
                    SB: begin
                        exp_sel[c+1] = 4'b0001 << (3 - a[1:0]);
                        exp_wdata[c+1] = {4{d[7:0]}};
                        ref_b[a[7:0]] = d[7:0];
                    end
                    SH: begin
                        exp_sel[c+1] = a[1] ? 4'b0011 : 4'b1100;
                        exp_wdata[c+1] = {2{d[15:0]}};
                        ref_b[a[7:0]] = d[15:8];
                        ref_b[8'(a[7:0] + 1)] = d[7:0];
                    end
                    default: begin
                        exp_sel[c+1] = 4'b1111;
                        exp_wdata[c+1] = d;
                        for (int k = 0; k < 4; k++) ref_b[8'(a[7:0] + k)] = d[31-8*k -: 8];
                    end
                endcase
            end
        end
        exp_done[t] = 1'b1;
        for (int k = c + 1; k <= t; k++) exp_busy[k] = 1'b1;
    endtask

    // One cycle of stimulus, applied at the falling edge of cycle `cyc`.
    task automatic tick(input bit v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] d, input bit r, output bit acc);
        @(negedge clk);
        rst = r; req_valid_i = v && !r; req_op_i = op; req_addr_i = a; req_wdata_i = d;
        acc = 1'b0;
        if (r) begin
            for (int k = cyc + 1; k <= cyc + 4; k++) begin
                exp_busy[k] = 0; exp_done[k] = 0; exp_adel[k] = 0; exp_ades[k] = 0;
                exp_ce[k] = 0; exp_we[k] = 0; exp_sel[k] = '0;
            end
            exp_rst[cyc+1] = 1'b1;
        end else if (v && !exp_busy[cyc]) begin
            acc = 1'b1;
            schedule(cyc, op, a, d);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) tick(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, acc);
    endtask

    task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                          output int acc_cyc);
        bit acc;
        acc_cyc = -1;
        for (int i = 0; i < 20 && acc_cyc < 0; i++) begin
            tick(1'b1, op, a, d, 1'b0, acc);
            if (acc) acc_cyc = cyc;
        end
        if (acc_cyc < 0) chk("accept_timeout", 32'h0, 32'h1);
    endtask

    // Per-cycle comparison against the expectation timeline.
    logic [31:0] cur_rdata = 32'h0;
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc < MAXC) begin
                if (exp_rst[cyc]) cur_rdata = 32'h0;
                if (exp_done[cyc]) cur_rdata = exp_rdv[cyc];
                chk("ready", {31'h0, req_ready_o}, {31'h0, !exp_busy[cyc]});
                chk("done",  {31'h0, done_o},      {31'h0, exp_done[cyc]});
                chk("adel",  {31'h0, adel_o},      {31'h0, exp_adel[cyc]});
                chk("ades",  {31'h0, ades_o},      {31'h0, exp_ades[cyc]});
                chk("ce",    {31'h0, ram_ce_o},    {31'h0, exp_ce[cyc]});
                chk("we",    {31'h0, ram_we_o},    {31'h0, exp_we[cyc]});
                chk("sel",   {28'h0, ram_sel_o},   {28'h0, exp_sel[cyc]});
                if (exp_ce[cyc]) chk("addr", ram_addr_o, exp_addr[cyc]);
                if (exp_we[cyc]) chk("wdata", ram_wdata_o, exp_wdata[cyc]);
                chk("rdata", rdata_o, cur_rdata);
            end
            if (ram_ce_o) begin
                ce_cnt++; strobe_at = cyc;
                strobe_sel = ram_sel_o; strobe_wdata = ram_wdata_o; strobe_addr = ram_addr_o;
            end
            if (done_o) begin
                done_at = cyc; done_rd = rdata_o; done_adel = adel_o; done_ades = ades_o;
            end
        end
    end

    initial begin
        #(MAXC * 10);
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1);
    end

    initial begin
        int c, c2, ce0;
        bit acc;
        logic [31:0] w5, d, a;
        logic [2:0] op;
        for (int i = 0; i < 256; i++) ref_b[i] = 8'($urandom);
        ref_b[32] = 8'h11; ref_b[33] = 8'h22; ref_b[34] = 8'h33; ref_b[35] = 8'h44;
        for (int i = 0; i < 64; i++)
            ram[i] = {ref_b[4*i], ref_b[4*i+1], ref_b[4*i+2], ref_b[4*i+3]};

        tick(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, acc);
        tick(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, acc);
        idle(1);
        chk("reset_ready", {31'h0, req_ready_o}, 32'h1);
        chk("reset_rdata", rdata_o, 32'h0);

        // SW then LW of the same word.
        do_req(SW, 32'h10, 32'hDEADBEEF, c); idle(3);
        chk("sw_strobe_cyc", 32'(strobe_at - c), 32'd1);
        chk("sw_sel", {28'h0, strobe_sel}, 32'hF);
        chk("sw_addr", strobe_addr, 32'h10);
        chk("sw_done_cyc", 32'(done_at - c), 32'd2);
        do_req(LW, 32'h10, 32'h0, c); idle(4);
        chk("lw_done_cyc", 32'(done_at - c), 32'd3);
        chk("lw_rdata", done_rd, 32'hDEADBEEF);

        // Byte store / loads in a big-endian word.
        do_req(SB, 32'h21, 32'h80, c); idle(3);
        chk("sb_sel", {28'h0, strobe_sel}, 32'h4);
        chk("sb_wdata", strobe_wdata, 32'h80808080);
        chk("sb_ram", ram[8], 32'h11803344);
        chk("model_lb", mdl_load(LB, 8'h21), 32'hFFFFFF80);
        do_req(LB, 32'h21, 32'h0, c); idle(4);
        chk("lb_rdata", done_rd, 32'hFFFFFF80);
        do_req(LBU, 32'h21, 32'h0, c); idle(4);
        chk("lbu_rdata", done_rd, 32'h00000080);

        // Halfword stores / loads.
        do_req(SH, 32'h32, 32'h8001, c); idle(3);
        chk("sh_sel", {28'h0, strobe_sel}, 32'h3);
        do_req(SH, 32'h30, 32'h7FFE, c); idle(3);
        chk("sh_ram", ram[12], 32'h7FFE8001);
        do_req(LH, 32'h32, 32'h0, c); idle(4);
        chk("lh_rdata", done_rd, 32'hFFFF8001);
        do_req(LHU, 32'h30, 32'h0, c); idle(4);
        chk("lhu_rdata", done_rd, 32'h00007FFE);

        // Misaligned accesses never reach the RAM.
        ce0 = ce_cnt;
        do_req(LW, 32'h13, 32'h0, c); idle(3);
        chk("adel_done_cyc", 32'(done_at - c), 32'd1);
        chk("adel_flag", {31'h0, done_adel}, 32'h1);
        w5 = ram[5];
        do_req(SH, 32'h15, 32'hABCD, c); idle(3);
        chk("ades_flag", {31'h0, done_ades}, 32'h1);
        chk("mis_no_ce", 32'(ce_cnt), 32'(ce0));
        chk("ades_ram", ram[5], w5);

        // Back-to-back loads with valid held high.
        c = -1; c2 = -1;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, LW, 32'h10, 32'h0, 1'b0, acc);
            if (acc && c < 0) c = cyc; else if (acc && c2 < 0) c2 = cyc;
        end
        idle(4);
        chk("b2b_gap", 32'(c2 - c), 32'd4);

        // Reset in the RD_WAIT cycle of a load.
        do_req(LW, 32'h10, 32'h0, c);
        idle(1);
        tick(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, acc);
        idle(1);
        chk("rst_rdwait_done", {31'h0, done_o}, 32'h0);
        chk("rst_rdwait_rdata", rdata_o, 32'h0);
        // Reset coinciding with a store strobe.
        do_req(SW, 32'h40, 32'hCAFE1234, c);
        tick(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, acc);
        idle(2);
        chk("rst_store_ram", ram[16], 32'hCAFE1234);
        do_req(LW, 32'h40, 32'h0, c); idle(4);

        // Randomized traffic, mostly aligned, with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            op = 3'($urandom);
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 4) != 0) begin
                if (op == LH || op == LHU || op == SH) a[0] = 1'b0;
                if (op == LW || op == SW) a[1:0] = 2'b00;
            end
            d = $urandom;
            tick($urandom_range(0, 2) != 0, op, a, d, $urandom_range(0, 99) == 0, acc);
        end
        tick(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, acc);
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Initiator side of the synchronous data RAM interface. It is the load/store unit in the MEM stage of the CPU.
- Accepts one load/store request at a time. It generates the RAM `ce`/`we`/`addr`/`sel`/`data_i` strobes and the byte-lane write data.
- It then extracts and sign- or zero-extends the returned word, and reports completion or an address-misalignment exception back to the pipeline.

Parameters:
- BIG_ENDIAN, 1: byte-lane mapping. 1 means byte offset k maps to lane 3-k. 0 means byte offset k maps to lane k.
- MEM_ADDR_W, 32: width of the byte address driven to the RAM. Full 32-bit bus; the RAM decodes its own index bits.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid_i  in  1  request present
- req_ready_o  out  1  high only in state IDLE; accept = req_valid_i && req_ready_o
- req_op_i  in  3  0=LB 1=LBU 2=LH 3=LHU 4=LW 5=SB 6=SH 7=SW
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-justified
- done_o  out  1  one-cycle completion pulse
- rdata_o  out  32  extended load result; valid while done_o=1 for a load
- adel_o  out  1  load misaligned; valid with done_o
- ades_o  out  1  store misaligned; valid with done_o
- ram_ce_o  out  1  to RAM ce
- ram_we_o  out  1  to RAM we
- ram_addr_o  out  32  to RAM addr, with bits [1:0] forced to 0
- ram_sel_o  out  4  to RAM sel; bit i enables data bits [8i+7:8i]
- ram_wdata_o  out  32  to RAM data_i
- ram_rdata_i  in  32  from RAM data_o; valid the cycle after a read strobe

Behaviour:
- Clock and reset: one clock, `clk`. `rst` is synchronous and active-high.
- Reset values: all outputs are registered and reset to 0, except `req_ready_o`, which is 1 because state resets to IDLE. Op, address, offset and data registers reset to 0.
- States: IDLE, ACCESS, RD_WAIT, RESP, using a 2-bit encoding.
- IDLE:
  - On accept, latch op, address and data.
  - If misaligned, go to RESP with the exception flag staged and no RAM strobe. Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - Otherwise load the RAM output registers and go to ACCESS.
- ACCESS:
  - Lasts exactly one cycle, with `ram_ce_o`=1.
  - Stores: `we`=1, `sel` and `wdata` set per the lane rules; next state RESP.
  - Loads: `we`=0, `sel`=1111; next state RD_WAIT.
  - On leaving ACCESS, `ce`/`we`/`sel` return to 0.
- RD_WAIT:
  - `ram_rdata_i` is valid.
  - Select the byte or halfword using the latched offset and `BIG_ENDIAN`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Register the result into `rdata_o`; next state RESP.
- RESP: `done_o`=1 for exactly one cycle, then IDLE. `rdata_o` holds its value until the next load completes. Stores and exceptions leave `rdata_o`=0 in their done cycle.
- Latency from the accept edge (accept in cycle 0):
  - Store: strobe in cycle 1, `done_o` in cycle 2.
  - Load: strobe in cycle 1, `done_o` in cycle 3.
  - Misaligned access: `done_o` in cycle 1, with `adel_o` or `ades_o` high.
- Peak throughput: one store per 3 cycles, one load per 4 cycles.
- Lane rules for stores (offset = addr[1:0]):
  - SB drives `wdata` = {4{b}}, with one `sel` bit at lane(offset).
  - SH drives {2{h}}, with `sel` 1100 for offset 0 and 0011 for offset 2 when BIG_ENDIAN=1; mirrored otherwise.
  - SW drives the full word with `sel` 1111.
- Ignored inputs: `req_valid_i` is ignored when `req_ready_o`=0. Request inputs are not sampled after accept.
- Reset during operation: the state machine returns to IDLE at the reset edge and no `done_o` is emitted. A RAM strobe already presented in the reset cycle still reaches the RAM, because reset is synchronous.
- Arithmetic: no address arithmetic. `ram_addr_o` = {addr[31:2], 2'b00}.

Decomposition:
- Shared define include holds:
  - LSU op codes (LB..SW);
  - state encodings;
  - byte/half/word width macros;
  - `ChipEnable`/`WriteEnable` levels, reused from the existing defines.
- One natural combinational sub-module, `lsu_lane_extract`. Inputs: op, offset, BIG_ENDIAN, 32-bit word. Output: the extended 32-bit result. `mem_lsu` instantiates it in the RD_WAIT path.

Test Plan:
- SW at addr 0x10 with data 0xDEADBEEF, then LW at 0x10 against a RAM model → cycle 1 of the store shows `ce`=1, `we`=1, `sel`=1111, `addr`=0x10; the store's `done_o` occurs in cycle 2; the load's `done_o` occurs 3 cycles after accept with `rdata_o`=0xDEADBEEF.
- SB 0x80 at 0x21, BIG_ENDIAN=1, RAM word 0x11223344 → `sel`=0100 and `wdata`=0x80808080. Then LB 0x21 → 0xFFFFFF80, and LBU 0x21 → 0x00000080.
- SH 0x8001 at 0x32 → `sel`=0011. Then LH 0x32 → 0xFFFF8001, and LHU 0x30 on word 0x7FFE8001 → 0x00007FFE.
- LW at 0x13 → `done_o` in cycle 1, `adel_o`=1, `ram_ce_o` never asserted. SH at 0x15 → `ades_o`=1, and RAM contents are unchanged.
- `req_valid_i` held high for back-to-back loads → `req_ready_o` low from cycle 1 to cycle 3; the second request is accepted in cycle 4; each request is accepted exactly once.
- `rst` asserted in the RD_WAIT cycle of a load → next cycle is IDLE with `done_o`=0 and `rdata_o`=0. A store strobe coinciding with `rst` still writes the RAM.
